// File: rtl/out_reg_stage.sv
// Output register stage. It holds a word (data, keep, last) under a valid/ready handshake.
// Latency: a word loaded at edge T is visible after edge T. Backpressure: it holds the word stable until ready_out.
// Ports: clk/reset (synchronous, active-low), load + load_* (the new word), ready_out, and valid/data/keep/last out.
module out_reg_stage #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              load_last,
    input  logic              ready_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic [KEEP_W-1:0] keep_out,
    output logic              last_out
);

    // The caller only asserts load when the register is empty or is
    // transferring on this edge. Load therefore takes priority over the drain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
        end else if (load) begin
            valid_out <= 1'b1;
            data_out  <= load_data;
            keep_out  <= load_keep;
            last_out  <= load_last;
        end else if (ready_out) begin
            // The word has transferred. Payload fields may keep stale values.
            valid_out <= 1'b0;
        end
    end

endmodule

// File: rtl/width_upsizer.sv
// Width upsizer. It packs RATIO narrow beats (lane 0 first) into one wide word, and last_in closes a group early.
// Latency: the completing beat accepted at edge T gives valid_out after edge T. Backpressure: ready_in = ~valid_out | ready_out.
// Ports: clk/reset (synchronous, active-low), narrow input (valid/ready/data/last), wide output (valid/ready/data/keep/last).
module width_upsizer #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      ready_in,
    input  logic                      valid_in,
    input  logic [IN_WIDTH-1:0]       data_in,
    input  logic                      last_in,
    input  logic                      ready_out,
    output logic                      valid_out,
    output logic [IN_WIDTH*RATIO-1:0] data_out,
    output logic [RATIO-1:0]          keep_out,
    output logic                      last_out
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [CNT_W-1:0]     cnt;
    logic [OUT_WIDTH-1:0] acc_data;
    logic [RATIO-1:0]     acc_keep;
    logic [OUT_WIDTH-1:0] merged_data;
    logic [RATIO-1:0]     merged_keep;
    logic                 accept;
    logic                 complete;

    // The block can always take a beat when the output slot frees up this cycle.
    // A completing beat then lands in the slot with no bubble.
    assign ready_in = ~valid_out | ready_out;
    assign accept   = valid_in & ready_in;
    assign complete = accept & ((cnt == CNT_W'(RATIO - 1)) | last_in);

    // Accumulator with the current beat merged into lane cnt.
    always_comb begin
        merged_data = acc_data;
        merged_data[cnt*IN_WIDTH +: IN_WIDTH] = data_in;
        merged_keep = acc_keep | (RATIO'(1) << cnt);
    end

    // Clearing on completion keeps unwritten lanes of the next partial word at zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= '0;
            acc_data <= '0;
            acc_keep <= '0;
        end else if (accept) begin
            if (complete) begin
                cnt      <= '0;
                acc_data <= '0;
                acc_keep <= '0;
            end else begin
                cnt      <= cnt + 1'b1;
                acc_data <= merged_data;
                acc_keep <= merged_keep;
            end
        end
    end

    out_reg_stage #(
        .DATA_W (OUT_WIDTH),
        .KEEP_W (RATIO)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (complete),
        .load_data (merged_data),
        .load_keep (merged_keep),
        .load_last (last_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .keep_out  (keep_out),
        .last_out  (last_out)
    );

endmodule

// File: tb/tb_width_upsizer.sv
// Testbench for width_upsizer (IN_WIDTH=8, RATIO=4).
// It uses directed scenarios plus a randomized run checked against a queue-based packing model.
// Inputs are driven on the falling edge, and outputs are sampled 1ns after the rising edge.
module tb_width_upsizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready_in;
    logic        valid_in;
    logic [7:0]  data_in;
    logic        last_in;
    logic        ready_out;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    width_upsizer #(.IN_WIDTH(8), .RATIO(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .ready_in  (ready_in),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .last_in   (last_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .keep_out  (keep_out),
        .last_out  (last_out)
    );

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic ro);
        @(negedge clk);
        valid_in  = v;
        data_in   = d;
        last_in   = l;
        ready_out = ro;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if ({valid_out, data_out, keep_out, last_out} !== 38'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h k=%h l=%b, want all 0", valid_out, data_out, keep_out, last_out);
        end
        n_checks++;
        if (ready_in !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_in: got %b, want 1", ready_in);
        end
        reset = 1'b1;
    endtask

    task automatic test_full_group;
        cycle(1'b1, 8'h11, 1'b0, 1'b1);
        cycle(1'b1, 8'h22, 1'b0, 1'b1);
        cycle(1'b1, 8'h33, 1'b0, 1'b1);
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL full_early_valid: got %b, want 0", valid_out);
        end
        cycle(1'b1, 8'h44, 1'b0, 1'b1);
        n_checks++;
        if (valid_out !== 1'b1 || data_out !== 32'h44332211 || keep_out !== 4'hF || last_out !== 1'b0) begin
            n_fail++;
            $display("FAIL full_word: got v=%b d=%h k=%h l=%b, want 1 44332211 f 0", valid_out, data_out, keep_out, last_out);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL full_valid_one_cycle: got %b, want 0", valid_out);
        end
    endtask

    task automatic test_partial_and_single;
        cycle(1'b1, 8'hAA, 1'b0, 1'b1);
        cycle(1'b1, 8'hBB, 1'b1, 1'b1);
        n_checks++;
        if (valid_out !== 1'b1 || data_out !== 32'h0000BBAA || keep_out !== 4'b0011 || last_out !== 1'b1) begin
            n_fail++;
            $display("FAIL partial_word: got v=%b d=%h k=%h l=%b, want 1 0000bbaa 3 1", valid_out, data_out, keep_out, last_out);
        end
        // The next group must restart at lane 0.
        cycle(1'b1, 8'h5A, 1'b1, 1'b1);
        n_checks++;
        if (valid_out !== 1'b1 || data_out !== 32'h0000005A || keep_out !== 4'b0001 || last_out !== 1'b1) begin
            n_fail++;
            $display("FAIL single_last: got v=%b d=%h k=%h l=%b, want 1 0000005a 1 1", valid_out, data_out, keep_out, last_out);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure;
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        // Offer a beat while stalled. It must not be consumed.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'h99, 1'b1, 1'b0);
            n_checks++;
            if (valid_out !== 1'b1 || ready_in !== 1'b0 || data_out !== 32'h04030201 || keep_out !== 4'hF || last_out !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b rdy=%b d=%h k=%h l=%b, want 1 0 04030201 f 0", i, valid_out, ready_in, data_out, keep_out, last_out);
            end
        end
        @(negedge clk);
        valid_in  = 1'b0;
        ready_out = 1'b1;
        #1;
        n_checks++;
        if (ready_in !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready_in: got %b, want 1", ready_in);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_transfer: valid_out got %b, want 0", valid_out);
        end
        // The stalled beat was not taken, so a fresh single beat sits in lane 0.
        cycle(1'b1, 8'h77, 1'b1, 1'b1);
        n_checks++;
        if (data_out !== 32'h00000077 || keep_out !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_no_consume: got d=%h k=%h, want 00000077 1", data_out, keep_out);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            valid_in  = 1'b1;
            data_in   = 8'(i + 1);
            last_in   = 1'b0;
            ready_out = 1'b1;
            #1;
            n_checks++;
            if (ready_in !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_ready_in[%0d]: got %b, want 1", i, ready_in);
            end
            @(posedge clk);
            #1;
            if (i == 3) begin
                n_checks++;
                if (valid_out !== 1'b1 || data_out !== 32'h04030201) begin
                    n_fail++;
                    $display("FAIL stream_word0: got v=%b d=%h, want 1 04030201", valid_out, data_out);
                end
            end
            if (i == 4) begin
                n_checks++;
                if (valid_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream_gap: got v=%b, want 0", valid_out);
                end
            end
            if (i == 7) begin
                n_checks++;
                if (valid_out !== 1'b1 || data_out !== 32'h08070605 || keep_out !== 4'hF) begin
                    n_fail++;
                    $display("FAIL stream_word1: got v=%b d=%h k=%h, want 1 08070605 f", valid_out, data_out, keep_out);
                end
            end
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_group;
        cycle(1'b1, 8'hDE, 1'b0, 1'b1);
        cycle(1'b1, 8'hAD, 1'b0, 1'b1);
        reset = 1'b0;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        reset = 1'b1;
        n_checks++;
        if ({valid_out, data_out, keep_out, last_out} !== 38'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got v=%b d=%h k=%h l=%b, want all 0", valid_out, data_out, keep_out, last_out);
        end
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b1);
        n_checks++;
        if (valid_out !== 1'b1 || data_out !== 32'h04030201 || keep_out !== 4'hF || last_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_word: got v=%b d=%h k=%h l=%b, want 1 04030201 f 0", valid_out, data_out, keep_out, last_out);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    // Randomized traffic against a packing model: the accepted bytes of the open
    // group sit in a queue, and formed words wait in an expected-word queue.
    task automatic test_random;
        logic [7:0]  grp[$];
        logic [31:0] exp_d[$];
        logic [3:0]  exp_k[$];
        logic        exp_l[$];
        logic        v, l, ro, acc, xfer;
        logic [7:0]  d;
        logic [31:0] w;
        logic [3:0]  k;
        reset = 1'b0;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            d  = 8'($urandom);
            l  = ($urandom_range(0, 5) == 0);
            ro = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            valid_in  = v;
            data_in   = d;
            last_in   = l;
            ready_out = ro;
            #1;
            n_checks++;
            if (valid_out !== (exp_d.size() != 0)) begin
                n_fail++;
                $display("FAIL rand_valid[%0d]: got %b, want %b", c, valid_out, exp_d.size() != 0);
            end
            n_checks++;
            if (ready_in !== (exp_d.size() == 0 || ro)) begin
                n_fail++;
                $display("FAIL rand_ready_in[%0d]: got %b, want %b", c, ready_in, exp_d.size() == 0 || ro);
            end
            xfer = (exp_d.size() != 0) && ro;
            acc  = v && (exp_d.size() == 0 || ro);
            if (xfer) begin
                n_checks++;
                if (data_out !== exp_d[0] || keep_out !== exp_k[0] || last_out !== exp_l[0]) begin
                    n_fail++;
                    $display("FAIL rand_word[%0d]: got d=%h k=%h l=%b, want d=%h k=%h l=%b", c, data_out, keep_out, last_out, exp_d[0], exp_k[0], exp_l[0]);
                end
                void'(exp_d.pop_front());
                void'(exp_k.pop_front());
                void'(exp_l.pop_front());
            end
            if (acc) begin
                grp.push_back(d);
                if (l || grp.size() == 4) begin
                    w = 32'h0;
                    k = 4'h0;
                    for (int j = 0; j < grp.size(); j++) begin
                        w = w | (32'(grp[j]) << (8 * j));
                        k[j] = 1'b1;
                    end
                    exp_d.push_back(w);
                    exp_k.push_back(k);
                    exp_l.push_back(l);
                    grp.delete();
                end
            end
            @(posedge clk);
        end
    endtask

    initial begin
        reset     = 1'b0;
        valid_in  = 1'b0;
        data_in   = 8'h00;
        last_in   = 1'b0;
        ready_out = 1'b0;
        test_reset();
        test_full_group();
        test_partial_and_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_group();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
